maze_nav_sequencer: RTL

- Parametrised successor to the hard-wired 5x5 navigation/draw state machine.
- Accepts move, turn-left, turn-right and U-turn commands through a valid/ready handshake, and checks moves against a runtime maze wall map.
- For each command it sequences a configurable number of animation frames; each frame issues a backpressured raster pixel scan for the ray-cast pipeline and ends with a double-buffer swap.
- It sits between ps2_controller and the pixel pipeline/render framebuffer writer.

---
 rtl/maze_nav_sequencer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/maze_nav_sequencer.sv
// rtl/maze_nav_sequencer.sv - command-driven maze navigation and animation frame sequencer
module maze_nav_sequencer #(
    parameter int ROWS        = 5,
    parameter int COLS        = 5,
    parameter int H_RES       = 800,
    parameter int V_RES       = 600,
    parameter int MOVE_FRAMES = 100,
    parameter int TURN_FRAMES = 90,
    parameter int ANGLE_STEPS = 360,
    parameter int START_X     = 0,
    parameter int START_Y     = 0,
    parameter int START_DIR   = 0
) (
    input  logic                                  clk_vga,
    input  logic                                  reset_btn,
    input  logic [ROWS*COLS-1:0]                  maze_wall,
    input  logic                                  cmd_valid,
    input  logic [2:0]                            cmd,
    output logic                                  cmd_ready,
    output logic [$clog2(ROWS)-1:0]               pos_x,
    output logic [$clog2(COLS)-1:0]               pos_y,
    output logic [1:0]                            dir,
    output logic [$clog2(ROWS*MOVE_FRAMES+1)-1:0] cam_x,
    output logic [$clog2(COLS*MOVE_FRAMES+1)-1:0] cam_y,
    output logic [$clog2(ANGLE_STEPS)-1:0]        angle,
    output logic [$clog2(H_RES)-1:0]              px,
    output logic [$clog2(V_RES)-1:0]              py,
    output logic                                  pix_valid,
    input  logic                                  pix_ready,
    output logic                                  frame_done,
    output logic                                  rd_buf,
    output logic                                  wr_buf,
    output logic                                  bump,
    output logic                                  busy
);
    localparam int XW   = $clog2(ROWS);
    localparam int YW   = $clog2(COLS);
    localparam int CXW  = $clog2(ROWS*MOVE_FRAMES+1);
    localparam int CYW  = $clog2(COLS*MOVE_FRAMES+1);
    localparam int AW   = $clog2(ANGLE_STEPS);
    localparam int HW   = $clog2(H_RES);
    localparam int VW   = $clog2(V_RES);
    localparam int WIW  = $clog2(ROWS*COLS);
    localparam int NMAX = (MOVE_FRAMES > 2*TURN_FRAMES) ? MOVE_FRAMES : 2*TURN_FRAMES;
    localparam int FW   = $clog2(NMAX+1);

    typedef enum logic [1:0] {S_IDLE, S_FRAME_INIT, S_SCAN, S_SWAP} state_t;
    typedef enum logic [1:0] {OP_MOVE, OP_LEFT, OP_RIGHT, OP_UTURN} op_t;

    state_t         state_q, state_d;
    op_t            op_q, op_d;
    logic [XW-1:0]  pos_x_q, pos_x_d, tgt_x_q, tgt_x_d, tgt_x;
    logic [YW-1:0]  pos_y_q, pos_y_d, tgt_y_q, tgt_y_d, tgt_y;
    logic [1:0]     dir_q, dir_d;
    logic [CXW-1:0] cam_x_q, cam_x_d;
    logic [CYW-1:0] cam_y_q, cam_y_d;
    logic [AW-1:0]  angle_q, angle_d;
    logic [HW-1:0]  px_q, px_d;
    logic [VW-1:0]  py_q, py_d;
    logic [FW-1:0]  frame_idx_q, frame_idx_d, n_q, n_d, off_q, off_d;
    logic           rd_buf_q, rd_buf_d, bump_q, bump_d;
    logic           blocked, accept, start_cmd, scan_last;
    logic [WIW-1:0] wall_idx;

    assign accept    = cmd_valid && cmd_ready;
    assign start_cmd = accept && ((cmd == 3'b001 && !blocked) || cmd == 3'b010 ||
                                  cmd == 3'b011 || cmd == 3'b100);
    assign scan_last = pix_ready && (px_q == HW'(H_RES-1)) && (py_q == VW'(V_RES-1));

    // Neighbour cell along the heading; blocked if it leaves the maze or is a wall
    always_comb begin
        tgt_x   = pos_x_q;
        tgt_y   = pos_y_q;
        blocked = 1'b0;
        unique case (dir_q)
            2'd0: if (pos_x_q == '0) blocked = 1'b1; else tgt_x = pos_x_q - XW'(1);
            2'd1: if (pos_y_q == '0) blocked = 1'b1; else tgt_y = pos_y_q - YW'(1);
            2'd2: if (pos_x_q == XW'(ROWS-1)) blocked = 1'b1; else tgt_x = pos_x_q + XW'(1);
            2'd3: if (pos_y_q == YW'(COLS-1)) blocked = 1'b1; else tgt_y = pos_y_q + YW'(1);
        endcase
        wall_idx = WIW'(int'(tgt_x) * COLS + int'(tgt_y));
        if (!blocked && maze_wall[wall_idx]) blocked = 1'b1;
    end

    // State register
    always_ff @(posedge clk_vga or posedge reset_btn) begin
        if (reset_btn) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:       if (start_cmd) state_d = S_FRAME_INIT;
            S_FRAME_INIT: state_d = S_SCAN;
            S_SCAN:       if (scan_last) state_d = S_SWAP;
            S_SWAP:       state_d = (frame_idx_q == n_q) ? S_IDLE : S_FRAME_INIT;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        cmd_ready  = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        pix_valid  = (state_q == S_SCAN);
        frame_done = (state_q == S_SWAP);
    end

    // Datapath next-state: command latch, per-frame camera step, pixel scan, commit
    always_comb begin
        op_d        = op_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        tgt_x_d     = tgt_x_q;
        tgt_y_d     = tgt_y_q;
        dir_d       = dir_q;
        cam_x_d     = cam_x_q;
        cam_y_d     = cam_y_q;
        angle_d     = angle_q;
        px_d        = px_q;
        py_d        = py_q;
        frame_idx_d = frame_idx_q;
        n_d         = n_q;
        off_d       = off_q;
        rd_buf_d    = rd_buf_q;
        bump_d      = 1'b0;
        unique case (state_q)
            S_IDLE: if (accept) begin
                frame_idx_d = '0;
                off_d       = '0;
                case (cmd)
                    3'b001: if (blocked) bump_d = 1'b1;
                            else begin
                                op_d = OP_MOVE; n_d = FW'(MOVE_FRAMES);
                                tgt_x_d = tgt_x; tgt_y_d = tgt_y;
                            end
                    3'b010: begin op_d = OP_LEFT;  n_d = FW'(TURN_FRAMES);   end
                    3'b011: begin op_d = OP_RIGHT; n_d = FW'(TURN_FRAMES);   end
                    3'b100: begin op_d = OP_UTURN; n_d = FW'(2*TURN_FRAMES); end
                    default: ;
                endcase
            end
            S_FRAME_INIT: begin
                frame_idx_d = frame_idx_q + FW'(1);
                px_d = '0;
                py_d = '0;
                unique case (op_q)
                    OP_MOVE: begin
                        off_d   = off_q + FW'(1);
                        cam_x_d = CXW'(int'(pos_x_q) * MOVE_FRAMES);
                        cam_y_d = CYW'(int'(pos_y_q) * MOVE_FRAMES);
                        unique case (dir_q)
                            2'd0: cam_x_d = CXW'(int'(pos_x_q) * MOVE_FRAMES - int'(off_d));
                            2'd1: cam_y_d = CYW'(int'(pos_y_q) * MOVE_FRAMES - int'(off_d));
                            2'd2: cam_x_d = CXW'(int'(pos_x_q) * MOVE_FRAMES + int'(off_d));
                            2'd3: cam_y_d = CYW'(int'(pos_y_q) * MOVE_FRAMES + int'(off_d));
                        endcase
                    end
                    OP_LEFT, OP_UTURN:
                        angle_d = (angle_q == '0) ? AW'(ANGLE_STEPS-1) : angle_q - AW'(1);
                    OP_RIGHT:
                        angle_d = (angle_q == AW'(ANGLE_STEPS-1)) ? '0 : angle_q + AW'(1);
                endcase
            end
            S_SCAN: if (pix_ready) begin
                if (px_q == HW'(H_RES-1)) begin
                    px_d = '0;
                    if (py_q != VW'(V_RES-1)) py_d = py_q + VW'(1);
                end else begin
                    px_d = px_q + HW'(1);
                end
            end
            S_SWAP: begin
                rd_buf_d = ~rd_buf_q;
                if (frame_idx_q == n_q) begin
                    unique case (op_q)
                        OP_MOVE:  begin pos_x_d = tgt_x_q; pos_y_d = tgt_y_q; off_d = '0; end
                        OP_LEFT:  dir_d = dir_q + 2'd1;
                        OP_RIGHT: dir_d = dir_q - 2'd1;
                        OP_UTURN: dir_d = dir_q + 2'd2;
                    endcase
                end
            end
        endcase
    end

    // Datapath registers; reset restores the start pose with camera aligned to it
    always_ff @(posedge clk_vga or posedge reset_btn) begin
        if (reset_btn) begin
            op_q        <= OP_MOVE;
            pos_x_q     <= XW'(START_X);
            pos_y_q     <= YW'(START_Y);
            tgt_x_q     <= XW'(START_X);
            tgt_y_q     <= YW'(START_Y);
            dir_q       <= 2'(START_DIR);
            cam_x_q     <= CXW'(START_X * MOVE_FRAMES);
            cam_y_q     <= CYW'(START_Y * MOVE_FRAMES);
            angle_q     <= AW'(((4 - START_DIR) % 4) * TURN_FRAMES);
            px_q        <= '0;
            py_q        <= '0;
            frame_idx_q <= '0;
            n_q         <= '0;
            off_q       <= '0;
            rd_buf_q    <= 1'b0;
            bump_q      <= 1'b0;
        end else begin
            op_q        <= op_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            tgt_x_q     <= tgt_x_d;
            tgt_y_q     <= tgt_y_d;
            dir_q       <= dir_d;
            cam_x_q     <= cam_x_d;
            cam_y_q     <= cam_y_d;
            angle_q     <= angle_d;
            px_q        <= px_d;
            py_q        <= py_d;
            frame_idx_q <= frame_idx_d;
            n_q         <= n_d;
            off_q       <= off_d;
            rd_buf_q    <= rd_buf_d;
            bump_q      <= bump_d;
        end
    end

    assign pos_x  = pos_x_q;
    assign pos_y  = pos_y_q;
    assign dir    = dir_q;
    assign cam_x  = cam_x_q;
    assign cam_y  = cam_y_q;
    assign angle  = angle_q;
    assign px     = px_q;
    assign py     = py_q;
    assign rd_buf = rd_buf_q;
    assign wr_buf = ~rd_buf_q;
    assign bump   = bump_q;
endmodule
